// File: rtl/cache_controller_if.sv
// Processor/RAM/data-array signal bundle for the direct-mapped cache controller.
// The controller connects through the slave modport; the environment uses master.
interface cache_controller_if #(
    parameter int CACHESIZEBITS = 10
);
    logic [31:0]              ProzessorAdresse;
    logic                     ProzessorLesen;
    logic                     ProzessorSchreiben;
    logic                     ProzessorBereit;
    logic                     RAMAnfrage;
    logic                     RAMSchreiben;
    logic [31:0]              RAMAdresse;
    logic                     RAMBereit;
    logic [CACHESIZEBITS-3:0] DatenIndex;
    logic                     DatenSchreiben;
    logic                     DatenQuelle;

    modport master (
        output ProzessorAdresse, ProzessorLesen, ProzessorSchreiben, RAMBereit,
        input  ProzessorBereit, RAMAnfrage, RAMSchreiben, RAMAdresse,
        input  DatenIndex, DatenSchreiben, DatenQuelle
    );

    modport slave (
        input  ProzessorAdresse, ProzessorLesen, ProzessorSchreiben, RAMBereit,
        output ProzessorBereit, RAMAnfrage, RAMSchreiben, RAMAdresse,
        output DatenIndex, DatenSchreiben, DatenQuelle
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped write-back cache controller: owns tag/valid/dirty state and
// sequences block writeback and refill against a word-wide RAM.
module cache_controller #(
    parameter int CACHESIZEBITS = 10,
    parameter int BLOCKSIZEBITS = 5
) (
    input logic               clock,
    input logic               reset,
    cache_controller_if.slave bus
);
    localparam int WB = BLOCKSIZEBITS - 2;
    localparam int IB = CACHESIZEBITS - BLOCKSIZEBITS;
    localparam int TB = 32 - CACHESIZEBITS;
    localparam int S  = 1 << IB;
    localparam int W  = 1 << WB;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        REFILL    = 2'd3
    } state_t;

    state_t          state;
    logic [WB-1:0]   cnt;
    logic [TB-1:0]   tags  [S];
    logic [S-1:0]    valid;
    logic [S-1:0]    dirty;

    logic [WB-1:0]   word;
    logic [IB-1:0]   idx;
    logic [TB-1:0]   tag;
    logic            hit;
    logic            last;
    logic            is_write;
    logic            unused_addr_lsb;

    assign word     = bus.ProzessorAdresse[BLOCKSIZEBITS-1:2];
    assign idx      = bus.ProzessorAdresse[CACHESIZEBITS-1:BLOCKSIZEBITS];
    assign tag      = bus.ProzessorAdresse[31:CACHESIZEBITS];
    assign hit      = valid[idx] && (tags[idx] == tag);
    assign last     = (cnt == WB'(W - 1));
    // A simultaneous read+write request is served as a write.
    assign is_write = bus.ProzessorSchreiben;
    assign unused_addr_lsb = ^bus.ProzessorAdresse[1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
            dirty <= '0;
            for (int i = 0; i < S; i++) begin
                tags[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ProzessorLesen || bus.ProzessorSchreiben) begin
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (is_write) begin
                            dirty[idx] <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= (valid[idx] && dirty[idx]) ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (bus.RAMBereit) begin
                        if (last) begin
                            cnt   <= '0;
                            state <= REFILL;
                        end else begin
                            cnt <= cnt + WB'(1);
                        end
                    end
                end
                REFILL: begin
                    if (bus.RAMBereit) begin
                        if (last) begin
                            // Block complete: install it and re-run the lookup, which now hits.
                            cnt        <= '0;
                            tags[idx]  <= tag;
                            valid[idx] <= 1'b1;
                            dirty[idx] <= 1'b0;
                            state      <= LOOKUP;
                        end else begin
                            cnt <= cnt + WB'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs follow the current state and same-cycle handshakes so a hit
    // completes in the lookup cycle and refill words land as RAM delivers them.
    always_comb begin
        bus.ProzessorBereit = 1'b0;
        bus.RAMAnfrage      = 1'b0;
        bus.RAMSchreiben    = 1'b0;
        bus.RAMAdresse      = '0;
        bus.DatenIndex      = '0;
        bus.DatenSchreiben  = 1'b0;
        bus.DatenQuelle     = 1'b0;
        case (state)
            LOOKUP: begin
                bus.DatenIndex = {idx, word};
                if (hit) begin
                    bus.ProzessorBereit = 1'b1;
                    bus.DatenSchreiben  = is_write;
                end
            end
            WRITEBACK: begin
                bus.RAMAnfrage   = 1'b1;
                bus.RAMSchreiben = 1'b1;
                bus.RAMAdresse   = {tags[idx], idx, cnt, 2'b00};
                bus.DatenIndex   = {idx, cnt};
            end
            REFILL: begin
                bus.RAMAnfrage = 1'b1;
                bus.RAMAdresse = {tag, idx, cnt, 2'b00};
                bus.DatenIndex = {idx, cnt};
                if (bus.RAMBereit) begin
                    bus.DatenSchreiben = 1'b1;
                    bus.DatenQuelle    = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller (CACHESIZEBITS=10, BLOCKSIZEBITS=5: 8 words/block, 32 sets).
module tb_cache_controller;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    cache_controller_if #(.CACHESIZEBITS(10)) bus ();

    cache_controller #(.CACHESIZEBITS(10), .BLOCKSIZEBITS(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_bereit"}, 32'(bus.ProzessorBereit), 32'd0);
        chk({tag, "_anfrage"}, 32'(bus.RAMAnfrage), 32'd0);
        chk({tag, "_ramschr"}, 32'(bus.RAMSchreiben), 32'd0);
        chk({tag, "_ramadr"}, bus.RAMAdresse, 32'd0);
        chk({tag, "_dschr"}, 32'(bus.DatenSchreiben), 32'd0);
        chk({tag, "_dquelle"}, 32'(bus.DatenQuelle), 32'd0);
    endtask

    // Runs one request to completion, checking every RAM word and the completion cycle.
    task automatic transact(input string name, input logic [31:0] a, input logic wr,
                            input logic both, input int exp_lat,
                            input int exp_nwb, input logic [31:0] wb_base,
                            input int exp_nrf, input logic [31:0] rf_base,
                            input int stall_word, input int stall_len);
        int   lat;
        int   nwb;
        int   nrf;
        int   stall_left;
        logic done;
        lat = 0; nwb = 0; nrf = 0; stall_left = stall_len; done = 1'b0;
        bus.ProzessorAdresse   = a;
        bus.ProzessorLesen     = !wr || both;
        bus.ProzessorSchreiben = wr;
        bus.RAMBereit          = 1'b1;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(posedge clock); #1;
            if (nwb == exp_nwb && nrf == stall_word && stall_left > 0) begin
                bus.RAMBereit = 1'b0;
                stall_left--;
            end else begin
                bus.RAMBereit = 1'b1;
            end
            @(negedge clock);
            if (bus.RAMAnfrage) begin
                if (bus.RAMSchreiben) begin
                    chk({name, "_wb_order"}, 32'(nrf), 32'd0);
                    chk({name, "_wb_adr"}, bus.RAMAdresse, wb_base + 32'(4 * nwb));
                    chk({name, "_wb_idx"}, 32'(bus.DatenIndex), 32'(wb_base[9:2]) + 32'(nwb));
                    chk({name, "_wb_dschr"}, 32'(bus.DatenSchreiben), 32'd0);
                    if (bus.RAMBereit) nwb++;
                end else begin
                    chk({name, "_rf_adr"}, bus.RAMAdresse, rf_base + 32'(4 * nrf));
                    chk({name, "_rf_dschr"}, 32'(bus.DatenSchreiben), 32'(bus.RAMBereit));
                    if (bus.RAMBereit) begin
                        chk({name, "_rf_quelle"}, 32'(bus.DatenQuelle), 32'd1);
                        chk({name, "_rf_idx"}, 32'(bus.DatenIndex), 32'(rf_base[9:2]) + 32'(nrf));
                        nrf++;
                    end
                end
            end else if (bus.ProzessorBereit) begin
                lat  = k;
                done = 1'b1;
                chk({name, "_hit_idx"}, 32'(bus.DatenIndex), 32'(a[9:2]));
                chk({name, "_hit_dschr"}, 32'(bus.DatenSchreiben), 32'(wr));
                chk({name, "_hit_quelle"}, 32'(bus.DatenQuelle), 32'd0);
            end else begin
                chk({name, "_wait_dschr"}, 32'(bus.DatenSchreiben), 32'd0);
            end
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_n_wb"}, 32'(nwb), 32'(exp_nwb));
        chk({name, "_n_rf"}, 32'(nrf), 32'(exp_nrf));
        @(posedge clock); #1;
        bus.ProzessorLesen     = 1'b0;
        bus.ProzessorSchreiben = 1'b0;
        bus.RAMBereit          = 1'b1;
    endtask

    initial begin
        int nrf;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.ProzessorAdresse   = 32'h0;
        bus.ProzessorLesen     = 1'b0;
        bus.ProzessorSchreiben = 1'b0;
        bus.RAMBereit          = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_quiet("reset");
        @(negedge clock);
        chk_quiet("idle");

        // Cold read miss, then hits in the same block, then a write hit.
        transact("rd40",  32'h0000_0040, 1'b0, 1'b0, 10, 0, 32'h0, 8, 32'h0000_0040, 0, 0);
        transact("rd44",  32'h0000_0044, 1'b0, 1'b0,  1, 0, 32'h0, 0, 32'h0, 0, 0);
        transact("wr48",  32'h0000_0048, 1'b1, 1'b0,  1, 0, 32'h0, 0, 32'h0, 0, 0);
        transact("both4c", 32'h0000_004C, 1'b1, 1'b1, 1, 0, 32'h0, 0, 32'h0, 0, 0);

        // Conflicting tag on the dirty set: writeback of old block then refill.
        transact("rd448", 32'h0000_0448, 1'b0, 1'b0, 18, 8, 32'h0000_0040, 8, 32'h0000_0440, 0, 0);
        transact("rd45c", 32'h0000_045C, 1'b0, 1'b0,  1, 0, 32'h0, 0, 32'h0, 0, 0);

        // Clean conflict miss with RAM stalling three cycles at word 3.
        transact("stall", 32'h0000_0840, 1'b0, 1'b0, 13, 0, 32'h0, 8, 32'h0000_0840, 3, 3);

        // Reset in the middle of a refill (word 4 on the bus).
        bus.ProzessorAdresse = 32'h0000_0C80;
        bus.ProzessorLesen   = 1'b1;
        bus.RAMBereit        = 1'b1;
        nrf = 0;
        for (int k = 1; k <= 20 && nrf < 4; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.RAMAnfrage && !bus.RAMSchreiben) nrf++;
        end
        chk("abort_words_before", 32'(nrf), 32'd4);
        @(posedge clock); #1;
        chk("abort_word4_adr", bus.RAMAdresse, 32'h0000_0C90);
        chk("abort_word4_anfrage", 32'(bus.RAMAnfrage), 32'd1);
        reset = 1'b1;
        bus.ProzessorLesen = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk_quiet("abort1");
        @(negedge clock);
        chk_quiet("abort2");

        // Everything was invalidated, so the same address refills fully again.
        transact("reread", 32'h0000_0C80, 1'b0, 1'b0, 10, 0, 32'h0, 8, 32'h0000_0C80, 0, 0);
        transact("rd40b", 32'h0000_0040, 1'b0, 1'b0, 10, 0, 32'h0, 8, 32'h0000_0040, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
